psum_add_arbiter: RTL

PSUM_ADD_ARBITER -- requirements
Module: psum_add_arbiter

---
 rtl/diff_core_pkg.sv | 8 +
 rtl/psum_add_arbiter_adder.sv | 12 +
 rtl/psum_add_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/diff_core_pkg.sv
// Shared datapath widths for the differential core and its partial-sum helpers.
package diff_core_pkg;

   localparam int PSUM_WIDTH = 16;

   typedef logic [PSUM_WIDTH-1:0] psum_t;

endpackage

// File: rtl/psum_add_arbiter_adder.sv
// Combinational partial-sum adder; the carry out is dropped, so results wrap.
module psum_add_arbiter_adder
   import diff_core_pkg::*;
(
   input  logic [PSUM_WIDTH-1:0] a,
   input  logic [PSUM_WIDTH-1:0] b,
   output logic [PSUM_WIDTH-1:0] ans
);

   assign ans = a + b;

endmodule

// File: rtl/psum_add_arbiter.sv
// Round-robin arbiter sharing one partial-sum adder among N_REQ requesters,
// with a single registered result slot that can drain and refill every cycle.
module psum_add_arbiter
   import diff_core_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_REQ-1:0]              req_valid,
   output logic [N_REQ-1:0]              req_ready,
   input  logic [N_REQ*PSUM_WIDTH-1:0]   req_a,
   input  logic [N_REQ*PSUM_WIDTH-1:0]   req_b,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [PSUM_WIDTH-1:0]         out_sum,
   output logic [$clog2(N_REQ)-1:0]      out_id,
   output logic [CNT_WIDTH-1:0]          txn_cnt
);

   localparam int IDX_W = $clog2(N_REQ);

   typedef logic [IDX_W-1:0] req_idx_t;

   logic                  out_valid_q, out_valid_d;
   logic [PSUM_WIDTH-1:0] out_sum_q, out_sum_d;
   req_idx_t              out_id_q, out_id_d;
   req_idx_t              rr_ptr_q, rr_ptr_d;
   logic [CNT_WIDTH-1:0]  txn_cnt_q, txn_cnt_d;

   req_idx_t              grant_idx;
   logic                  grant_found;
   logic                  slot_free;
   logic                  handshake;
   int                    scan_idx;
   logic [PSUM_WIDTH-1:0] op_a, op_b, sum;

   // Search starts at rr_ptr, so the last winner is always checked last.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = 0;
      for (int k = 0; k < N_REQ; k++) begin
         scan_idx = int'(rr_ptr_q) + k;
         if (scan_idx >= N_REQ) begin
            scan_idx = scan_idx - N_REQ;
         end
         if (!grant_found && req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = req_idx_t'(scan_idx);
         end
      end
   end

   // Gating with rst_n keeps req_ready low for the whole reset interval.
   always_comb begin
      slot_free = rst_n & (~out_valid_q | out_ready);
      handshake = slot_free & grant_found;
      req_ready = '0;
      if (handshake) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      op_a = req_a[grant_idx*PSUM_WIDTH +: PSUM_WIDTH];
      op_b = req_b[grant_idx*PSUM_WIDTH +: PSUM_WIDTH];
   end

   psum_add_arbiter_adder u_adder (
      .a   (op_a),
      .b   (op_b),
      .ans (sum)
   );

   always_comb begin
      out_valid_d = handshake | (out_valid_q & ~out_ready);
      out_sum_d   = handshake ? sum : out_sum_q;
      out_id_d    = handshake ? grant_idx : out_id_q;
      rr_ptr_d    = rr_ptr_q;
      if (handshake) begin
         rr_ptr_d = (grant_idx == req_idx_t'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      txn_cnt_d   = txn_cnt_q + CNT_WIDTH'(handshake);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_id_q    <= '0;
         rr_ptr_q    <= '0;
         txn_cnt_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_id_q    <= out_id_d;
         rr_ptr_q    <= rr_ptr_d;
         txn_cnt_q   <= txn_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_id    = out_id_q;
   assign txn_cnt   = txn_cnt_q;

endmodule
